display_scan_ctrl: RTL

Time-multiplexing scan controller for the stopwatch's 8-digit seven-segment display. It drives the select input of the 8:1 4-bit digit mux and receives the mux output back as `digit_in`. Scan order is digit 7 down to digit 0. For each digit it applies the matching active-low anode enable, with a ghosting guard interval, leading-zero suppression, per-digit blanking and decimal-point control. It sits between the stopwatch counter/mux datapath and the seven-segment decoder/pins.

---
 rtl/display_scan_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexing scan controller for an up-to-8-digit seven-segment display.
// Walks sel from NUM_DIGITS-1 down to 0, one slot of REFRESH_DIV cycles per digit.
// Each slot opens with DEAD_CYCLES all-dark guard cycles. The slot's anode/dp
// decision is then latched once and held for the remainder of the slot.
//
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   en           - scan enable; low forces the display dark and restarts the scan
//   lz_en        - leading-zero suppression enable (digit 0 is never suppressed)
//   blank_mask   - per-digit forced blanking
//   dp_mask      - per-digit decimal point enable
//   digit_in     - digit value returned by the external mux for the current sel
//   sel          - digit select to the mux (registered)
//   an           - active-low anode enables (registered)
//   dp_n         - active-low decimal point (registered)
//   slot_tick    - pulse on the last cycle of every completed slot
//   frame_done   - pulse on the last cycle of a completed digit-0 slot
module display_scan_ctrl #(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned DEAD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       lz_en,
   input  logic [7:0] blank_mask,
   input  logic [7:0] dp_mask,
   input  logic [3:0] digit_in,
   output logic [2:0] sel,
   output logic [7:0] an,
   output logic       dp_n,
   output logic       slot_tick,
   output logic       frame_done
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(REFRESH_DIV - 2);
   localparam logic [CNT_W-1:0] CNT_GEND = CNT_W'(DEAD_CYCLES - 1);
   localparam logic [2:0]       SEL_MAX  = 3'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GUARD = 2'd1,
      ON    = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             seen_nz, seen_nz_d;
   logic [2:0]       sel_d;
   logic [7:0]       an_d;
   logic             dp_n_d;
   logic             slot_tick_d;
   logic             frame_done_d;
   logic             blank;

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         seen_nz    <= 1'b0;
         sel        <= SEL_MAX;
         an         <= 8'hFF;
         dp_n       <= 1'b1;
         slot_tick  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         seen_nz    <= seen_nz_d;
         sel        <= sel_d;
         an         <= an_d;
         dp_n       <= dp_n_d;
         slot_tick  <= slot_tick_d;
         frame_done <= frame_done_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      seen_nz_d    = seen_nz;
      sel_d        = sel;
      an_d         = an;
      dp_n_d       = dp_n;
      slot_tick_d  = 1'b0;
      frame_done_d = 1'b0;

      // Digit 0 is exempt from suppression so a zero value always shows one digit
      blank = blank_mask[sel] |
              (lz_en & (sel != 3'd0) & ~seen_nz & (digit_in == 4'd0));

      if (!en) begin
         state_d   = IDLE;
         cnt_d     = '0;
         seen_nz_d = 1'b0;
         sel_d     = SEL_MAX;
         an_d      = 8'hFF;
         dp_n_d    = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               state_d = GUARD;
               cnt_d   = '0;
               sel_d   = SEL_MAX;
               an_d    = 8'hFF;
               dp_n_d  = 1'b1;
            end
            GUARD: begin
               cnt_d = cnt + CNT_W'(1);
               if (cnt == CNT_GEND) begin
                  state_d   = ON;
                  an_d      = 8'hFF;
                  an_d[sel] = blank;
                  dp_n_d    = blank | ~dp_mask[sel];
                  seen_nz_d = seen_nz | (digit_in != 4'd0);
               end
            end
            ON: begin
               if (cnt == CNT_LAST) begin
                  state_d = GUARD;
                  cnt_d   = '0;
                  an_d    = 8'hFF;
                  dp_n_d  = 1'b1;
                  if (sel == 3'd0) begin
                     sel_d     = SEL_MAX;
                     seen_nz_d = 1'b0;
                  end else begin
                     sel_d = sel - 3'd1;
                  end
               end else begin
                  cnt_d = cnt + CNT_W'(1);
                  // Pulses are registered, so they are raised one cycle early
                  if (cnt == CNT_PRE) begin
                     slot_tick_d  = 1'b1;
                     frame_done_d = (sel == 3'd0);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               sel_d   = SEL_MAX;
               an_d    = 8'hFF;
               dp_n_d  = 1'b1;
            end
         endcase
      end
   end

endmodule
